// File: rtl/stopwatch_pkg.sv
// Shared command codes for the stopwatch timer interface and the button
// front-end's mirror of the timer run state.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CTRL_NONE  = 2'd0,
    CTRL_START = 2'd1,
    CTRL_PAUSE = 2'd2,
    CTRL_STOP  = 2'd3
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debounce counter and a one-cycle
// press pulse raised in the cycle whose closing edge flips the level 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = ~level_q;
      cnt_d   = '0;
      press   = ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button front-end for the stopwatch timer: debounces start/pause and stop,
// mirrors the timer run state and issues one-cycle ctrl commands.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 20,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_pause,
  input  logic       btn_stop,
  output logic [1:0] ctrl,
  output logic       running,
  output logic       paused
);

  logic raw_sp, raw_stop;
  logic sp_level, stop_level;
  logic sp_press, stop_press;
  logic unused_levels;

  assign raw_sp   = BTN_ACTIVE_LOW ? ~btn_start_pause : btn_start_pause;
  assign raw_stop = BTN_ACTIVE_LOW ? ~btn_stop        : btn_stop;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sp (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_sp),
    .level  (sp_level),
    .press  (sp_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_stop (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_stop),
    .level  (stop_level),
    .press  (stop_press)
  );

  // Only the press pulses drive the FSM; the levels are kept for observability.
  assign unused_levels = sp_level ^ stop_level;

  state_e state_q, state_d;
  ctrl_e  ctrl_q,  ctrl_d;
  logic   running_q, running_d;
  logic   paused_q,  paused_d;

  always_comb begin
    state_d = state_q;
    ctrl_d  = CTRL_NONE;
    // Stop wins a same-cycle collision and swallows the start/pause press.
    if (stop_press) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        ctrl_d  = CTRL_STOP;
      end
    end else if (sp_press) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSED;
        ctrl_d  = CTRL_PAUSE;
      end else begin
        state_d = ST_RUN;
        ctrl_d  = CTRL_START;
      end
    end
    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= CTRL_NONE;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      running_q <= running_d;
      paused_q  <= paused_d;
    end
  end

  assign ctrl    = ctrl_q;
  assign running = running_q;
  assign paused  = paused_q;

endmodule
